// File: rtl/radix4_multiple_select_pkg.sv
// rtl/radix4_multiple_select_pkg.sv - shared state/digit codes and sizing helpers for the radix-4 multiple selector
package radix4_multiple_select_pkg;

  typedef logic [1:0] digit_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam digit_t DIG_ZERO  = 2'd0;
  localparam digit_t DIG_ONE   = 2'd1;
  localparam digit_t DIG_TWO   = 2'd2;
  localparam digit_t DIG_THREE = 2'd3;

  function automatic int iter_of(input int n);
    return n / 2;
  endfunction

  // Digit counter width; kept at least 1 bit so a 2-bit operand still has a counter.
  function automatic int cnt_width(input int n);
    return (n / 2 > 1) ? $clog2(n / 2) : 1;
  endfunction

endpackage

// File: rtl/radix4_multiple_select_if.sv
// rtl/radix4_multiple_select_if.sv - selected-multiple beat stream (valid/ready); sel_idx present under RADIX4_SEL_IDX_EN
interface radix4_multiple_select_if
  import radix4_multiple_select_pkg::*;
#(
  parameter int N = 1024
);
  logic [N+3:0] sel_out;
  logic         sel_valid;
  logic         sel_ready;
  logic         sel_last;
`ifdef RADIX4_SEL_IDX_EN
  logic [cnt_width(N)-1:0] sel_idx;
`endif

  modport master (
`ifdef RADIX4_SEL_IDX_EN
    output sel_idx,
`endif
    output sel_out,
    output sel_valid,
    output sel_last,
    input  sel_ready
  );

  modport slave (
`ifdef RADIX4_SEL_IDX_EN
    input  sel_idx,
`endif
    input  sel_out,
    input  sel_valid,
    input  sel_last,
    output sel_ready
  );

endinterface

// File: rtl/radix4_multiple_select_mult_mux4.sv
// rtl/radix4_multiple_select_mult_mux4.sv - combinational radix-4 digit to zero-extended multiple select
module mult_mux4
  import radix4_multiple_select_pkg::*;
#(
  parameter int N = 1024
) (
  input  digit_t       digit_i,
  input  logic [N-1:0] a_i,
  input  logic [N:0]   a2_i,
  input  logic [N+3:0] a3_i,
  output logic [N+3:0] mult_o
);

  always_comb begin
    mult_o = '0;
    case (digit_i)
      DIG_ONE:   mult_o = {4'b0000, a_i};
      DIG_TWO:   mult_o = {3'b000, a2_i};
      DIG_THREE: mult_o = a3_i;
      default:   mult_o = '0;
    endcase
  end

endmodule

// File: rtl/radix4_multiple_select.sv
// rtl/radix4_multiple_select.sv - walks B in 2-bit digits emitting 0/A/2A/3A beats; RADIX4_SEL_IDX_EN adds sel_idx
module radix4_multiple_select
  import radix4_multiple_select_pkg::*;
#(
  parameter int N = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [N-1:0]                    b_in,
  input  logic                            mult_done,
  input  logic [N-1:0]                    a_in,
  input  logic [N:0]                      a2_in,
  input  logic [N+3:0]                    a3_in,
  radix4_multiple_select_if.master        sel,
  output logic                            busy,
  output logic                            done
);

  localparam int ITER = iter_of(N);
  localparam int CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST  = CW'(ITER - 1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  b_sr_q, b_sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N:0]    a2_q, a2_d;
  logic [N+3:0]  a3_q, a3_d;
  logic          mult_ok_q, mult_ok_d;
  logic [N+3:0]  sel_out_q, sel_out_d;
  logic          sel_valid_q, sel_valid_d;
  logic          sel_last_q, sel_last_d;
  logic [CW-1:0] idx_q, idx_d;

  logic          latch;
  logic [N-1:0]  a_eff;
  logic [N:0]    a2_eff;
  logic [N+3:0]  a3_eff;
  logic [N-1:0]  b_shift;
  logic [CW-1:0] cnt_inc;
  digit_t        digit;
  logic [N+3:0]  mux_out;

  // Multiples are frozen while streaming; in WAIT a same-cycle mult_done feeds the mux directly.
  assign latch   = mult_done && (state_q != ST_STREAM);
  assign a_eff   = latch ? a_in  : a_q;
  assign a2_eff  = latch ? a2_in : a2_q;
  assign a3_eff  = latch ? a3_in : a3_q;
  assign b_shift = b_sr_q >> 2;
  assign cnt_inc = cnt_q + ONE_C;
  assign digit   = (state_q == ST_STREAM) ? b_shift[1:0] : b_sr_q[1:0];

  mult_mux4 #(.N(N)) u_mux (
    .digit_i (digit),
    .a_i     (a_eff),
    .a2_i    (a2_eff),
    .a3_i    (a3_eff),
    .mult_o  (mux_out)
  );

  always_comb begin
    state_d     = state_q;
    b_sr_d      = b_sr_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    a2_d        = a2_q;
    a3_d        = a3_q;
    mult_ok_d   = mult_ok_q;
    sel_out_d   = sel_out_q;
    sel_valid_d = sel_valid_q;
    sel_last_d  = sel_last_q;
    idx_d       = idx_q;

    if (latch) begin
      a_d       = a_in;
      a2_d      = a2_in;
      a3_d      = a3_in;
      mult_ok_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          b_sr_d  = b_in;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mult_ok_q || latch) begin
          state_d     = ST_STREAM;
          sel_out_d   = mux_out;
          sel_valid_d = 1'b1;
          sel_last_d  = (cnt_q == LAST);
          idx_d       = cnt_q;
        end
      end
      ST_STREAM: begin
        if (sel_valid_q && sel.sel_ready) begin
          if (cnt_q == LAST) begin
            state_d     = ST_DONE;
            sel_valid_d = 1'b0;
            sel_last_d  = 1'b0;
          end else begin
            b_sr_d     = b_shift;
            cnt_d      = cnt_inc;
            sel_out_d  = mux_out;
            sel_last_d = (cnt_inc == LAST);
            idx_d      = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (!latch) mult_ok_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      b_sr_q      <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      mult_ok_q   <= 1'b0;
      sel_out_q   <= '0;
      sel_valid_q <= 1'b0;
      sel_last_q  <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      b_sr_q      <= b_sr_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      a2_q        <= a2_d;
      a3_q        <= a3_d;
      mult_ok_q   <= mult_ok_d;
      sel_out_q   <= sel_out_d;
      sel_valid_q <= sel_valid_d;
      sel_last_q  <= sel_last_d;
      idx_q       <= idx_d;
    end
  end

  assign sel.sel_out   = sel_out_q;
  assign sel.sel_valid = sel_valid_q;
  assign sel.sel_last  = sel_last_q;
`ifdef RADIX4_SEL_IDX_EN
  assign sel.sel_idx   = idx_q;
`else
  logic unused_idx;
  assign unused_idx = ^idx_q;
`endif
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_radix4_multiple_select.sv
// tb/tb_radix4_multiple_select.sv - scoreboard bench for radix4_multiple_select at N=8 and N=1024
module tb_radix4_multiple_select;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start8, md8, busy8, done8;
  logic [7:0]  b8, a8;
  logic [8:0]  a2_8;
  logic [11:0] a3_8;

  logic           startk, mdk, busyk, donek;
  logic [1023:0]  bk, ak;
  logic [1024:0]  a2k;
  logic [1027:0]  a3k;

  radix4_multiple_select_if #(.N(8))    s8 ();
  radix4_multiple_select_if #(.N(1024)) sk ();

  radix4_multiple_select #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .b_in(b8), .mult_done(md8),
    .a_in(a8), .a2_in(a2_8), .a3_in(a3_8), .sel(s8.master), .busy(busy8), .done(done8)
  );

  radix4_multiple_select #(.N(1024)) dutk (
    .clk(clk), .reset(reset), .start(startk), .b_in(bk), .mult_done(mdk),
    .a_in(ak), .a2_in(a2k), .a3_in(a3k), .sel(sk.master), .busy(busyk), .done(donek)
  );

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  bit          last_q[$];

  task automatic set_mult8(input logic [7:0] a);
    a8   = a;
    a2_8 = {a, 1'b0};
    a3_8 = {4'b0, a} + {3'b0, a, 1'b0};
  endtask

  task automatic pulse_md8(input logic [7:0] a);
    set_mult8(a);
    md8 = 1'b1;
    @(negedge clk);
    md8 = 1'b0;
  endtask

  task automatic pulse_start8(input logic [7:0] b);
    b8 = b;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic push8(input logic [7:0] a, input logic [7:0] b);
    logic [11:0] ax;
    ax = {4'b0, a};
    for (int i = 0; i < 4; i++) begin
      case (b[2*i +: 2])
        2'd0: exp_q.push_back(12'd0);
        2'd1: exp_q.push_back(ax);
        2'd2: exp_q.push_back(ax * 12'd2);
        default: exp_q.push_back(ax * 12'd3);
      endcase
      last_q.push_back(i == 3);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s8.sel_out, s8.sel_valid, s8.sel_last, busy8, done8} !== 16'h0) begin
      failures++;
      $display("FAIL reset_state got out=%h v=%b l=%b busy=%b done=%b want all 0",
               s8.sel_out, s8.sel_valid, s8.sel_last, busy8, done8);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc = 0;
    s8.sel_ready = 1'b1;
    pulse_md8(8'h05);
    push8(8'h05, 8'hE4);
    pulse_start8(8'hE4);
    checks++;
    if (s8.sel_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency_t1 got valid=%b want 0", s8.sel_valid);
    end
    @(negedge clk);
    checks++;
    if (s8.sel_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency_t2 got valid=%b want 1", s8.sel_valid);
    end
    while (exp_q.size() > 0 && cyc < 40) begin
      if (s8.sel_valid) begin
        checks++;
        if (s8.sel_out !== exp_q[0] || s8.sel_last !== last_q[0]) begin
          failures++;
          $display("FAIL basic_beat got %h/%b want %h/%b", s8.sel_out, s8.sel_last, exp_q[0], last_q[0]);
        end
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || done8 !== 1'b1 || s8.sel_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got left=%0d done=%b valid=%b want 0/1/0", exp_q.size(), done8, s8.sel_valid);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got done=%b busy=%b want 0/0", done8, busy8);
    end
  endtask

  task automatic test_mult_late;
    int cyc = 0;
    int early = 0;
    s8.sel_ready = 1'b1;
    push8(8'h07, 8'h1B);
    pulse_start8(8'h1B);
    repeat (5) begin
      if (s8.sel_valid !== 1'b0) early++;
      @(negedge clk);
    end
    checks++;
    if (early != 0 || busy8 !== 1'b1) begin
      failures++;
      $display("FAIL late_wait got early_valid=%0d busy=%b want 0/1", early, busy8);
    end
    pulse_md8(8'h07);
    checks++;
    if (s8.sel_valid !== 1'b1) begin
      failures++;
      $display("FAIL late_valid got %b want 1", s8.sel_valid);
    end
    while (exp_q.size() > 0 && cyc < 40) begin
      if (s8.sel_valid) begin
        checks++;
        if (s8.sel_out !== exp_q[0] || s8.sel_last !== last_q[0]) begin
          failures++;
          $display("FAIL late_beat got %h/%b want %h/%b", s8.sel_out, s8.sel_last, exp_q[0], last_q[0]);
        end
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || done8 !== 1'b1) begin
      failures++;
      $display("FAIL late_done got left=%0d done=%b want 0/1", exp_q.size(), done8);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int cyc = 0;
    int beats = 0;
    pulse_md8(8'h09);
    push8(8'h09, 8'h9C);
    pulse_start8(8'h9C);
    while (exp_q.size() > 0 && cyc < 60) begin
      s8.sel_ready = pat[cyc % 4];
      if (s8.sel_valid) begin
        checks++;
        if (s8.sel_out !== exp_q[0] || s8.sel_last !== last_q[0]) begin
          failures++;
          $display("FAIL stall_beat got %h/%b want %h/%b", s8.sel_out, s8.sel_last, exp_q[0], last_q[0]);
        end
        if (s8.sel_ready) begin
          void'(exp_q.pop_front());
          void'(last_q.pop_front());
          beats++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (beats != 4 || s8.sel_valid !== 1'b0 || done8 !== 1'b1) begin
      failures++;
      $display("FAIL stall_total got beats=%0d valid=%b done=%b want 4/0/1", beats, s8.sel_valid, done8);
    end
    s8.sel_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    int dones = 0;
    s8.sel_ready = 1'b1;
    pulse_md8(8'h0D);
    push8(8'h0D, 8'h6C);
    pulse_start8(8'h6C);
    while (exp_q.size() > 2 && cyc < 40) begin
      if (s8.sel_valid) begin
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({s8.sel_out, s8.sel_valid, s8.sel_last, busy8, done8} !== 16'h0) begin
      failures++;
      $display("FAIL abort_state got out=%h v=%b l=%b busy=%b done=%b want all 0",
               s8.sel_out, s8.sel_valid, s8.sel_last, busy8, done8);
    end
    repeat (3) begin
      if (done8 !== 1'b0) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done got %0d done cycles want 0", dones);
    end
    exp_q.delete();
    last_q.delete();
    pulse_md8(8'h0B);
    push8(8'h0B, 8'h2D);
    pulse_start8(8'h2D);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (s8.sel_valid) begin
        checks++;
        if (s8.sel_out !== exp_q[0] || s8.sel_last !== last_q[0]) begin
          failures++;
          $display("FAIL rerun_beat got %h/%b want %h/%b", s8.sel_out, s8.sel_last, exp_q[0], last_q[0]);
        end
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || done8 !== 1'b1) begin
      failures++;
      $display("FAIL rerun_done got left=%0d done=%b want 0/1", exp_q.size(), done8);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_mult;
    int cyc = 0;
    int stray = 0;
    s8.sel_ready = 1'b1;
    pulse_md8(8'h03);
    push8(8'h03, 8'hB1);
    pulse_start8(8'hB1);
    while (exp_q.size() > 0 && cyc < 40) begin
      if (cyc == 2) begin
        set_mult8(8'h0E);
        md8 = 1'b1;
      end else begin
        md8 = 1'b0;
      end
      if (s8.sel_valid) begin
        checks++;
        if (s8.sel_out !== exp_q[0] || s8.sel_last !== last_q[0]) begin
          failures++;
          $display("FAIL frozen_beat got %h/%b want %h/%b", s8.sel_out, s8.sel_last, exp_q[0], last_q[0]);
        end
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    md8 = 1'b0;
    checks++;
    if (exp_q.size() != 0 || done8 !== 1'b1) begin
      failures++;
      $display("FAIL frozen_done got left=%0d done=%b want 0/1", exp_q.size(), done8);
    end
    @(negedge clk);
    pulse_start8(8'h55);
    repeat (6) begin
      if (s8.sel_valid !== 1'b0 || busy8 !== 1'b1) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL second_start_waits got %0d bad cycles want 0", stray);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wide;
    logic [1027:0] exp3;
    int cyc = 0;
    int beats = 0;
    int dones = 0;
    for (int i = 0; i < 32; i++) ak[i*32 +: 32] = $urandom;
    a2k  = {ak, 1'b0};
    a3k  = {4'b0, ak} * 1028'd3;
    exp3 = {4'b0, ak} + {4'b0, ak} + {4'b0, ak};
    bk = '1;
    sk.sel_ready = 1'b1;
    mdk = 1'b1;
    @(negedge clk);
    mdk = 1'b0;
    startk = 1'b1;
    @(negedge clk);
    startk = 1'b0;
    while (beats < 512 && cyc < 700) begin
      if (donek) dones++;
      if (sk.sel_valid) begin
        checks++;
        if (sk.sel_out !== exp3 || sk.sel_last !== (beats == 511)) begin
          failures++;
          $display("FAIL wide_beat %0d got last=%b out=%h want last=%b", beats, sk.sel_last, sk.sel_out, beats == 511);
        end
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    repeat (3) begin
      if (donek) dones++;
      @(negedge clk);
    end
    checks++;
    if (beats != 512 || dones != 1 || busyk !== 1'b0) begin
      failures++;
      $display("FAIL wide_total got beats=%0d dones=%0d busy=%b want 512/1/0", beats, dones, busyk);
    end
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0; md8 = 1'b0; b8 = '0;
    set_mult8(8'h00);
    startk = 1'b0; mdk = 1'b0; bk = '0; ak = '0; a2k = '0; a3k = '0;
    s8.sel_ready = 1'b0;
    sk.sel_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_mult_late;
    test_stall;
    test_reset_mid;
    test_mid_mult;
    test_wide;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
